// File: rtl/pipe_stage_fifo_pkg.sv
// Shared types for the pipeline-stage FIFO.
// fifo_op_e encodes the {pop, push} pair that the pointer/count update
// decodes each cycle.
package pipe_stage_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_fifo_mem.sv
// Entry storage for pipe_stage_fifo: DEPTH x W register array with one
// write port and an asynchronous read port. Entries are zeroed on reset.
module pipe_fifo_mem #(
  parameter int W     = 102,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  // Synchronous clear on reset, otherwise write the addressed entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Pipeline-stage register with DEPTH-entry storage and valid/allowin
// handshakes on both sides. in_allowin depends only on occupancy, so no
// combinational path runs from out_allowin to in_allowin.
// Optional feature: define PIPE_FIFO_STALL_CNT_EN to add a saturating
// stall_cnt output counting cycles the head entry is held by downstream.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int PAYLOAD_W = 96,
  parameter int EXC_W     = 5,
  parameter int DEPTH     = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_flush,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_rf_we,
  input  logic [EXC_W-1:0]     in_exc,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [EXC_W-1:0]     out_exc,
  output logic                 out_exc_any,
  output logic                 out_rf_we,
  output logic [CW-1:0]        occupancy
`ifdef PIPE_FIFO_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = PAYLOAD_W + 1 + EXC_W;

  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          w_push;
  logic          w_pop;
  fifo_op_e      w_op;
  logic [EW-1:0] w_rd_data;

  logic [PAYLOAD_W-1:0] w_head_payload;
  logic                 w_head_rf_we;
  logic [EXC_W-1:0]     w_head_exc;

  // Explicit wrap so non-power-of-two depths never address a missing entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign in_allowin = (r_count < CW'(DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid & in_allowin & ~pipe_flush;
  assign w_pop      = out_valid & out_allowin & ~pipe_flush;
  assign w_op       = fifo_op_e'({w_pop, w_push});

  // Pointer and count update; flush empties the stage, reset has priority.
  always_ff @(posedge clk) begin
    if (!rst_n || pipe_flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          r_count  <= r_count + CW'(1);
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        OP_POP: begin
          r_count  <= r_count - CW'(1);
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        OP_BOTH: begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        default: ;
      endcase
    end
  end

  pipe_fifo_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({in_payload, in_rf_we, in_exc}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign {w_head_payload, w_head_rf_we, w_head_exc} = w_rd_data;

  // Head outputs are forced to zero when the stage is empty; an entry
  // carrying any exception flag never writes the register file.
  assign out_payload = out_valid ? w_head_payload : '0;
  assign out_exc     = out_valid ? w_head_exc : '0;
  assign out_exc_any = |out_exc;
  assign out_rf_we   = out_valid & w_head_rf_we & ~(|w_head_exc);
  assign occupancy   = r_count;

`ifdef PIPE_FIFO_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of backpressure cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_allowin && !pipe_flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=3 instance share one
// input stream and are each compared against a queue-based model.
module tb_pipe_stage_fifo;

  typedef struct {
    logic [95:0] pl;
    logic        we;
    logic [4:0]  exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_flush;
  logic        in_valid;
  logic [95:0] in_payload;
  logic        in_rf_we;
  logic [4:0]  in_exc;
  logic        out_allowin;

  logic        ov   [2];
  logic        ia   [2];
  logic [95:0] opl  [2];
  logic [4:0]  oexc [2];
  logic        oany [2];
  logic        owe  [2];
  logic [1:0]  occ  [2];
  logic [31:0] stall_cnt;

  ent_t        q [2][$];
  int          dep [2] = '{2, 3};
  logic [31:0] m_stall;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.PAYLOAD_W(96), .EXC_W(5), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_allowin(ia[0]), .in_payload(in_payload),
    .in_rf_we(in_rf_we), .in_exc(in_exc),
    .out_valid(ov[0]), .out_allowin(out_allowin), .out_payload(opl[0]),
    .out_exc(oexc[0]), .out_exc_any(oany[0]), .out_rf_we(owe[0]),
    .occupancy(occ[0])
`ifdef PIPE_FIFO_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pipe_stage_fifo #(.PAYLOAD_W(96), .EXC_W(5), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .in_valid(in_valid), .in_allowin(ia[1]), .in_payload(in_payload),
    .in_rf_we(in_rf_we), .in_exc(in_exc),
    .out_valid(ov[1]), .out_allowin(out_allowin), .out_payload(opl[1]),
    .out_exc(oexc[1]), .out_exc_any(oany[1]), .out_rf_we(owe[1]),
    .occupancy(occ[1])
`ifdef PIPE_FIFO_STALL_CNT_EN
    , .stall_cnt()
`endif
  );

`ifndef PIPE_FIFO_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare every output of both instances against the model's view.
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      ent_t  h;
      logic  v;
      string s;
      s = (k == 0) ? "d2" : "d3";
      v = (q[k].size() > 0);
      h.pl = '0; h.we = 1'b0; h.exc = '0;
      if (v) h = q[k][0];
      chk({s, "_valid"},   96'(ov[k]),   96'(v));
      chk({s, "_allowin"}, 96'(ia[k]),   96'(q[k].size() < dep[k]));
      chk({s, "_payload"}, opl[k],       h.pl);
      chk({s, "_exc"},     96'(oexc[k]), 96'(h.exc));
      chk({s, "_exc_any"}, 96'(oany[k]), 96'(h.exc != 5'd0));
      chk({s, "_rf_we"},   96'(owe[k]),  96'(v && h.we && h.exc == 5'd0));
      chk({s, "_occ"},     96'(occ[k]),  96'(q[k].size()));
    end
`ifdef PIPE_FIFO_STALL_CNT_EN
    chk("stall_cnt", 96'(stall_cnt), 96'(m_stall));
`endif
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check,
  // then advance the model and the clock.
  task automatic step(input logic rst, input logic fl, input logic v, input logic oa,
                      input logic [95:0] pl, input logic we, input logic [4:0] exc);
    ent_t e;
    rst_n = rst; pipe_flush = fl; in_valid = v; out_allowin = oa;
    in_payload = pl; in_rf_we = we; in_exc = exc;
    #1;
    check_all();
    if (!rst) m_stall = '0;
    else if (q[0].size() > 0 && !oa && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
    e.pl = pl; e.we = we; e.exc = exc;
    for (int k = 0; k < 2; k++) begin
      if (!rst || fl) begin
        q[k].delete();
      end else begin
        logic do_push;
        do_push = v && (q[k].size() < dep[k]);
        if (q[k].size() > 0 && oa) void'(q[k].pop_front());
        if (do_push) q[k].push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pipe_flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0;
    in_payload = '0; in_rf_we = 1'b0; in_exc = '0;
    m_stall = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
    chk("rst_valid", 96'(ov[0]), 96'd0);
    chk("rst_allowin", 96'(ia[0]), 96'd1);

    // Streaming with downstream always ready.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 96'h11 + 96'(i), 1'b0, 5'd0);
    chk("t1_occ", 96'(occ[0]), 96'd1);
    chk("t1_payload", opl[0], 96'h16);

    // Backpressure: A, B accepted, C held upstream, then drained in order.
    step(1'b0, 1'b0, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'hA, 1'b1, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'hB, 1'b1, 5'd0);
    chk("t2_full_allowin", 96'(ia[0]), 96'd0);
    chk("t2_head_a", opl[0], 96'hA);
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'hC, 1'b1, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 96'hC, 1'b1, 5'd0);
    chk("t2_head_b", opl[0], 96'hB);
    step(1'b1, 1'b0, 1'b1, 1'b1, 96'hC, 1'b1, 5'd0);
    chk("t2_head_c", opl[0], 96'hC);
    step(1'b1, 1'b0, 1'b0, 1'b1, 96'h0, 1'b0, 5'd0);

    // Flush while full with a concurrent push.
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'h21, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'h22, 1'b0, 5'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 96'h23, 1'b0, 5'd0);
    chk("t3_occ", 96'(occ[0]), 96'd0);
    chk("t3_valid", 96'(ov[0]), 96'd0);
    chk("t3_allowin", 96'(ia[0]), 96'd1);

    // Exception entry suppresses the RF write; a clean entry does not.
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'hDEAD, 1'b1, 5'b00100);
    chk("t4_rf_we_exc", 96'(owe[0]), 96'd0);
    chk("t4_exc_any", 96'(oany[0]), 96'd1);
    chk("t4_payload", opl[0], 96'hDEAD);
    step(1'b1, 1'b1, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'hBEEF, 1'b1, 5'd0);
    chk("t4_rf_we_clean", 96'(owe[0]), 96'd1);

    // Stall counter: 7 held cycles, survives flush, cleared by reset.
    step(1'b0, 1'b0, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 96'h77, 1'b0, 5'd0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
`ifdef PIPE_FIFO_STALL_CNT_EN
    chk("t6_stall_7", 96'(stall_cnt), 96'd7);
`endif
    step(1'b1, 1'b1, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
`ifdef PIPE_FIFO_STALL_CNT_EN
    chk("t6_stall_flush", 96'(stall_cnt), 96'd7);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);
`ifdef PIPE_FIFO_STALL_CNT_EN
    chk("t6_stall_rst", 96'(stall_cnt), 96'd0);
`endif

    // Random traffic across pointer wrap, with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] exc;
      exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom),
           {$urandom, $urandom, $urandom}, 1'($urandom), exc);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 96'h0, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
